// File: rtl/mem_arbiter.sv
// mem_arbiter: arbiter/sequencer for the unified line memory shared by I-refill and D-fill/writeback
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_req, i_addr              I-side line read request (held until i_done)
//   i_done, i_rd_data          I-side completion pulse and registered line data
//   d_req, d_we, d_addr,
//   d_wr_data                  D-side read (d_we=0) or writeback (d_we=1) request
//   d_done, d_rd_data          D-side completion pulse and registered read data
//   m_re, m_we, m_addr,
//   m_wr_data, m_rd_data,
//   m_rdy                      memory strobes, address/data and completion handshake
//   wb_full                    one-entry write buffer holds an undrained line
module mem_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 64,
    parameter int STARVE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rd_data,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wr_data,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rd_data,
    output logic              m_re,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wr_data,
    input  logic [DATA_W-1:0] m_rd_data,
    input  logic              m_rdy,
    output logic              wb_full
);
    localparam int CW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE);
    typedef enum logic [2:0] {IDLE, RD_I, RD_D, DRAIN, RESP} state_t;
    state_t state, next;
    logic resp_i, wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [CW-1:0] starve_cnt;
    logic d_wr, d_rd, hit_d, hit_i, i_starved;
    logic g_cap, g_fwd_d, g_fwd_i, g_d, g_i;
    always_comb begin
        d_wr      = d_req & d_we;
        d_rd      = d_req & ~d_we;
        hit_d     = wb_valid && d_addr == wb_addr;
        hit_i     = wb_valid && i_addr == wb_addr;
        i_starved = i_req && starve_cnt == SMAX;
        next      = state;
        g_cap     = 1'b0;
        g_fwd_d   = 1'b0;
        g_fwd_i   = 1'b0;
        case (state)
            IDLE: begin
                if (d_wr && !wb_valid) begin
                    next  = RESP;
                    g_cap = 1'b1;
                end else if (d_wr) begin
                    next = DRAIN;
                end else if (d_rd && hit_d) begin
                    next    = RESP;
                    g_fwd_d = 1'b1;
                end else if (d_rd && !i_starved) begin
                    next = RD_D;
                end else if (i_req && hit_i) begin
                    next    = RESP;
                    g_fwd_i = 1'b1;
                end else if (i_req) begin
                    next = RD_I;
                end else if (wb_valid) begin
                    next = DRAIN;
                end
            end
            RD_I, RD_D: next = m_rdy ? RESP : state;
            DRAIN:      next = m_rdy ? IDLE : DRAIN;
            default:    next = IDLE;
        endcase
        // A missing D read yields to a starved I read; every other D request is a D grant.
        g_d = state == IDLE && d_req && !(d_rd && !hit_d && i_starved);
        g_i = state == IDLE && i_req && !g_d;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= next;
    assign m_re    = state == RD_I || state == RD_D;
    assign m_we    = state == DRAIN;
    assign i_done  = state == RESP && resp_i;
    assign d_done  = state == RESP && !resp_i;
    assign wb_full = wb_valid;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_i     <= 1'b0;
            wb_valid   <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            m_addr     <= '0;
            m_wr_data  <= '0;
            i_rd_data  <= '0;
            d_rd_data  <= '0;
            starve_cnt <= '0;
        end else begin
            if (state == IDLE && next == RD_I) m_addr <= i_addr;
            if (state == IDLE && next == RD_D) m_addr <= d_addr;
            if (state == IDLE && next == DRAIN) begin
                m_addr    <= wb_addr;
                m_wr_data <= wb_data;
            end
            if (g_i)      resp_i <= 1'b1;
            else if (g_d) resp_i <= 1'b0;
            if (g_cap) begin
                wb_valid <= 1'b1;
                wb_addr  <= d_addr;
                wb_data  <= d_wr_data;
            end else if (state == DRAIN && m_rdy) begin
                wb_valid <= 1'b0;
            end
            if (g_fwd_d)                    d_rd_data <= wb_data;
            else if (state == RD_D && m_rdy) d_rd_data <= m_rd_data;
            if (g_fwd_i)                    i_rd_data <= wb_data;
            else if (state == RD_I && m_rdy) i_rd_data <= m_rd_data;
            if (g_i)                                         starve_cnt <= '0;
            else if (g_d && i_req && starve_cnt != SMAX)     starve_cnt <= starve_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a latency-programmable memory model
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [13:0] i_addr = '0, d_addr = '0;
    logic [63:0] d_wr_data = '0, rd_val = '0;
    logic        i_done, d_done, m_re, m_we, m_rdy, wb_full;
    logic [63:0] i_rd_data, d_rd_data, m_wr_data;
    logic [13:0] m_addr;
    int          lat = 100;
    int          scnt = 0, nre = 0, nwe = 0, nboth = 0, dcnt = 0;
    logic [13:0] last_waddr = '0;
    logic [63:0] last_wdata = '0;
    int          n_chk = 0, n_fail = 0;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rd_data(i_rd_data),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wr_data(d_wr_data),
        .d_done(d_done), .d_rd_data(d_rd_data),
        .m_re(m_re), .m_we(m_we), .m_addr(m_addr), .m_wr_data(m_wr_data),
        .m_rd_data(rd_val), .m_rdy(m_rdy), .wb_full(wb_full)
    );

    always #5 clk = ~clk;

    // Memory answers in the lat-th cycle of a strobe.
    assign m_rdy = (m_re || m_we) && scnt == lat - 1;
    always @(posedge clk) begin
        scnt <= ((m_re || m_we) && !m_rdy) ? scnt + 1 : 0;
        if (m_re) nre <= nre + 1;
        if (m_we) nwe <= nwe + 1;
        if (m_re && m_we) nboth <= nboth + 1;
        if (d_done) dcnt <= dcnt + 1;
        if (m_we && m_rdy) begin
            last_waddr <= m_addr;
            last_wdata <= m_wr_data;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Cycles (negedges) until the selected done pulse is seen; -1 if the bound expires.
    task automatic wait_done(input bit side_i, input int max, output int t);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(side_i ? i_done : d_done) && t < max);
        if (!(side_i ? i_done : d_done)) t = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int t, snap;
        logic [5:0] order;
        int ndone;
        repeat (2) @(negedge clk);
        check("rst_m_re", m_re, 0);
        check("rst_m_we", m_we, 0);
        check("rst_dones", {i_done, d_done}, 0);
        check("rst_wb_full", wb_full, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_d_rd_data", d_rd_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        // Buffered writeback, then a read miss that never completes, then async reset.
        d_req = 1; d_we = 1; d_addr = 14'h0200; d_wr_data = 64'h5555_AAAA_5555_AAAA;
        wait_done(0, 5, t);
        check("wb0_lat", t, 1);
        check("wb0_full", wb_full, 1);
        d_we = 0; d_addr = 14'h0300;
        repeat (2) @(negedge clk);
        check("rdd_m_re", m_re, 1);
        check("rdd_m_addr", m_addr, 14'h0300);
        #2 rst_n = 1'b0;
        #1;
        check("arst_m_re", m_re, 0);
        check("arst_wb_full", wb_full, 0);
        check("arst_m_addr", m_addr, 0);
        check("arst_m_wr_data", m_wr_data, 0);
        check("arst_dones", {i_done, d_done}, 0);
        @(negedge clk);
        rst_n = 1'b1; d_req = 0;
        @(negedge clk);
        // I miss, memory ready in the 4th strobe cycle.
        i_req = 1; i_addr = 14'h0010; lat = 4; rd_val = 64'h0123_4567_89AB_CDEF;
        wait_done(1, 20, t);
        check("imiss_lat", t, 5);
        check("imiss_data", i_rd_data, 64'h0123_4567_89AB_CDEF);
        i_req = 0;
        @(negedge clk);
        // Writeback then forwarded read: no memory traffic.
        snap = nre + nwe;
        d_req = 1; d_we = 1; d_addr = 14'h0040; d_wr_data = 64'hDEAD_BEEF_CAFE_F00D;
        wait_done(0, 5, t);
        check("wb_lat", t, 1);
        d_we = 0;
        wait_done(0, 5, t);
        check("fwd_lat", t, 2);
        check("fwd_data", d_rd_data, 64'hDEAD_BEEF_CAFE_F00D);
        check("fwd_no_mem", nre + nwe - snap, 0);
        // Read miss goes out ahead of the buffered writeback.
        d_addr = 14'h0080; lat = 2; rd_val = 64'h1111_2222_3333_4444;
        repeat (2) @(negedge clk);
        check("miss_first_re", {m_re, m_we}, 2'b10);
        check("miss_addr", m_addr, 14'h0080);
        wait_done(0, 10, t);
        check("miss_lat", t, 2);
        check("miss_data", d_rd_data, 64'h1111_2222_3333_4444);
        d_req = 0;
        for (int k = 0; k < 20 && !m_we; k++) @(negedge clk);
        check("drain_we", m_we, 1);
        check("drain_addr", m_addr, 14'h0040);
        check("drain_data", m_wr_data, 64'hDEAD_BEEF_CAFE_F00D);
        check("drain_full", wb_full, 1);
        for (int k = 0; k < 20 && wb_full; k++) @(negedge clk);
        check("drain_clear", wb_full, 0);
        check("drain_mem_addr", last_waddr, 14'h0040);
        // Starvation: both sides request continuously.
        lat = 1; order = '0; ndone = 0;
        i_req = 1; i_addr = 14'h0500; d_req = 1; d_we = 0; d_addr = 14'h0600;
        for (int k = 0; k < 60 && ndone < 6; k++) begin
            @(negedge clk);
            if (i_done || d_done) begin
                order = {order[4:0], i_done};
                ndone++;
            end
        end
        i_req = 0; d_req = 0;
        check("starve_cnt", ndone, 6);
        check("starve_order", order, 6'b001001);
        @(negedge clk);
        // Second writeback into a full buffer.
        snap = dcnt;
        d_req = 1; d_we = 1; d_addr = 14'h0700; d_wr_data = 64'hAAAA_0000_0000_0001;
        wait_done(0, 5, t);
        check("wb1_lat", t, 1);
        d_addr = 14'h0800; d_wr_data = 64'hBBBB_0000_0000_0002; lat = 3;
        wait_done(0, 20, t);
        check("wb2_lat", t, 6);
        d_req = 0;
        repeat (2) @(negedge clk);
        check("wb2_done_once", dcnt - snap, 2);
        check("wb2_first_drain_addr", last_waddr, 14'h0700);
        check("wb2_first_drain_data", last_wdata, 64'hAAAA_0000_0000_0001);
        check("wb2_full", wb_full, 1);
        for (int k = 0; k < 20 && wb_full; k++) @(negedge clk);
        check("wb2_drain_addr", last_waddr, 14'h0800);
        check("wb2_drain_data", last_wdata, 64'hBBBB_0000_0000_0002);
        check("never_both", nboth, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
